// File: rtl/demux2_5b_sync_pkg.sv
// Shared definitions for the 2:1 5-bit link demultiplexer: FSM encoding,
// channel tag values and the default channel width.
package demux2_5b_sync_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        GOT1  = 2'b01,
        GOT2  = 2'b10,
        PAIR  = 2'b11
    } state_t;

    localparam logic SEL_CH1   = 1'b0;
    localparam logic SEL_CH2   = 1'b1;
    localparam int   WIDTH_DEF = 5;

endpackage

// File: rtl/demux2_5b_sync_pair_counter.sv
// Free-running wrapping counter of consumed pairs; advances by one per enabled cycle.
module pair_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/demux2_5b_sync.sv
// Reassembles a sel-tagged 5-bit time-multiplexed stream into a registered
// (out1, out2) pair offered through valid/ready, and counts consumed pairs.
module demux2_5b_sync
    import demux2_5b_sync_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             sel,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out1,
    output logic [WIDTH-1:0] out2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             err_dup,
    output logic [CNT_W-1:0] pair_cnt
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] out1_q, out1_d;
    logic [WIDTH-1:0] out2_q, out2_d;
    logic             err_q, err_d;
    logic             accept;
    logic             consume;

    // Only combinational input-to-output path: a held pair frees the input once the consumer takes it.
    assign in_ready = (state_q == PAIR) ? out_ready : 1'b1;
    assign accept   = in_valid && in_ready;
    assign consume  = (state_q == PAIR) && out_ready;

    always_comb begin
        state_d = state_q;
        out1_d  = out1_q;
        out2_d  = out2_q;
        err_d   = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    if (sel == SEL_CH1) begin
                        out1_d  = in_data;
                        state_d = GOT1;
                    end else begin
                        out2_d  = in_data;
                        state_d = GOT2;
                    end
                end
            end
            GOT1: begin
                if (accept) begin
                    if (sel == SEL_CH2) begin
                        out2_d  = in_data;
                        state_d = PAIR;
                    end else begin
                        out1_d = in_data;
                        err_d  = 1'b1;
                    end
                end
            end
            GOT2: begin
                if (accept) begin
                    if (sel == SEL_CH1) begin
                        out1_d  = in_data;
                        state_d = PAIR;
                    end else begin
                        out2_d = in_data;
                        err_d  = 1'b1;
                    end
                end
            end
            PAIR: begin
                // A beat arriving with the consume starts the next pair without a bubble.
                if (consume) begin
                    if (accept) begin
                        if (sel == SEL_CH1) begin
                            out1_d  = in_data;
                            state_d = GOT1;
                        end else begin
                            out2_d  = in_data;
                            state_d = GOT2;
                        end
                    end else begin
                        state_d = EMPTY;
                    end
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            out1_q  <= '0;
            out2_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out1_q  <= out1_d;
            out2_q  <= out2_d;
            err_q   <= err_d;
        end
    end

    pair_counter #(
        .CNT_W(CNT_W)
    ) u_pair_counter (
        .clk  (clk),
        .rst  (rst),
        .en_i (consume),
        .cnt_o(pair_cnt)
    );

    assign out1      = out1_q;
    assign out2      = out2_q;
    assign out_valid = (state_q == PAIR);
    assign err_dup   = err_q;

endmodule

// File: doc/demux2_5b_sync.md
Name: demux2_5b_sync

Overview:
- Receiving end of the 2:1 5-bit time-multiplexed link driven by Mux2_5b.
- Captures a shared 5-bit stream tagged by sel and reassembles it into a registered (out1, out2) pair.
- Presents each pair through a valid/ready handshake and counts completed pairs.
- Sits between the muxed datapath and any consumer that needs both 5-bit fields, e.g. rt/rd register addresses, on the same cycle.

Parameters:
- WIDTH, 5, data width of each channel and of the shared input.
- CNT_W, 8, width of the completed-pair counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_data  input  WIDTH  shared multiplexed data.
- sel  input  1  channel tag for in_data: 0 = channel 1 (in1), 1 = channel 2 (in2). Same encoding as the mux select.
- in_valid  input  1  in_data/sel valid this cycle.
- in_ready  output  1  block accepts a beat this cycle.
- out1  output  WIDTH  reassembled channel-1 value.
- out2  output  WIDTH  reassembled channel-2 value.
- out_valid  output  1  out1/out2 form a complete pair.
- out_ready  input  1  consumer takes the pair.
- err_dup  output  1  one-cycle pulse: a channel was received twice before its partner.
- pair_cnt  output  CNT_W  number of pairs consumed; wraps modulo 2^CNT_W.

Behaviour:
- Beat accepted when in_valid && in_ready. Pair consumed when out_valid && out_ready.
- Reset (rst=1 at a clock edge): state=EMPTY, out1=0, out2=0, out_valid=0, err_dup=0, pair_cnt=0. in_ready=1 after reset.
- Reset mid-pair discards any partial capture. rst has priority over every other event.
- States: EMPTY, GOT1, GOT2, PAIR. out_valid=1 only in PAIR. out_valid is a registered state decode, with no combinational path from inputs.
- in_ready is 1 in EMPTY/GOT1/GOT2. In PAIR, in_ready = out_ready (the only combinational path).
- EMPTY: accepted beat with sel=0 -> out1<=in_data, go GOT1. With sel=1 -> out2<=in_data, go GOT2.
- GOT1, accepted sel=1 -> out2<=in_data, go PAIR.
- GOT1, accepted sel=0 -> out1<=in_data (newest wins), stay GOT1, err_dup=1 next cycle.
- GOT2 is symmetric: sel=0 completes the pair; sel=1 overwrites out2 and pulses err_dup.
- PAIR, no consume -> hold out1/out2 stable and remain in PAIR. Input is back-pressured.
- PAIR, consume with no beat -> go EMPTY. out1/out2 keep their values (don't-care while out_valid=0).
- PAIR, consume and beat on the same cycle -> pair_cnt increments, the beat is captured per its sel, next state is GOT1 (sel=0) or GOT2 (sel=1).
- Throughput: one pair per 2 cycles sustained, with no bubble.
- Latency: out_valid rises on the cycle after the edge that accepts the second beat.
- pair_cnt increments by 1 on each consume and wraps from 2^CNT_W-1 to 0 without a flag.
- err_dup is a single-cycle registered pulse and is never asserted in the same cycle as a state change to PAIR.
- in_valid=0 cycles are ignored in every state, and sel is ignored when no beat is accepted.

Decomposition:
- Shared package: state encoding (EMPTY=2'b00, GOT1=2'b01, GOT2=2'b10, PAIR=2'b11), the SEL_CH1=0 / SEL_CH2=1 constants, and WIDTH default 5.
- One natural sub-module: pair_counter (CNT_W-bit wrapping counter with sync reset and enable).
- FSM and capture registers stay in the top module.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then in_valid=0 for 10 cycles -> out_valid=0, in_ready=1, out1=out2=0, pair_cnt=0.
- Basic pair: beat (sel=0, 5'b00011), then (sel=1, 5'b00100), out_ready=1 -> out_valid=1 one cycle after the second beat with out1=00011 and out2=00100, then pair_cnt=1.
- Reverse order plus back-pressure: (sel=1, 5'b11011), then (sel=0, 5'b11100), out_ready=0 for 3 cycles -> pair held stable, in_ready=0, a third offered beat is not taken. Then out_ready=1 -> consumed, pair_cnt=1.
- Duplicate: (sel=0, 01010), (sel=0, 10101), (sel=1, 00001) -> err_dup pulses exactly once, then the pair is out1=10101, out2=00001.
- Streaming with wrap: sel toggles every cycle with in_valid=1, out_ready=1, and in_data inverted each beat, for 512 beats -> 256 pairs with no stall, and pair_cnt wraps from 255 to 0.
- Reset mid-operation: after beat (sel=0, 00111), assert rst for 1 cycle, then (sel=1, 01000) -> state GOT2 with no pair formed, and out_valid stays 0 until a sel=0 beat arrives.
